// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters and holds each
// result in a per-requester response slot until the requester accepts it.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration. When it is
// undefined, requester 0 has fixed priority and there is no rr_ptr register.

package rv32i_types;
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;
endpackage

// Shared ALU. slts turns sra into a signed compare and sub into an unsigned compare.
module alu
  import rv32i_types::*;
(
  input  alu_ops      aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        slts,
  output logic [31:0] f
);

  // Purely combinational operation select
  always_comb begin
    f = '0;
    case (aluop)
      alu_add: f = a + b;
      alu_sll: f = a << b[4:0];
      alu_sra: f = slts ? {31'b0, $signed(a) < $signed(b)}
                        : 32'($signed(a) >>> b[4:0]);
      alu_sub: f = slts ? {31'b0, a < b} : a - b;
      alu_xor: f = a ^ b;
      alu_srl: f = a >> b[4:0];
      alu_or:  f = a | b;
      alu_and: f = a & b;
      default: f = '0;
    endcase
  end

endmodule

module alu_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_aluop,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic            req0_slts,
  input  logic [ID_W-1:0] req0_id,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_aluop,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic            req1_slts,
  input  logic [ID_W-1:0] req1_id,

  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [31:0]     resp0_data,
  output logic [ID_W-1:0] resp0_id,

  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [31:0]     resp1_data,
  output logic [ID_W-1:0] resp1_id
);

  localparam int unsigned DATA_W = 32;

  logic              elig0, elig1;
  logic              grant0, grant1;
  logic [2:0]        alu_op_sel;
  logic [DATA_W-1:0] alu_a_sel, alu_b_sel, alu_f;
  logic              alu_slts_sel;

  logic              resp0_valid_q, resp1_valid_q;
  logic [DATA_W-1:0] resp0_data_q, resp1_data_q;
  logic [ID_W-1:0]   resp0_id_q, resp1_id_q;

  // A full slot only blocks its own requester, and only if it is not draining now
  always_comb begin
    elig0 = req0_valid && (!resp0_valid_q || resp0_ready);
    elig1 = req1_valid && (!resp1_valid_q || resp1_ready);
  end

`ifdef ALU_ARB_RR_EN
  logic rr_ptr_q;

  // Round-robin: on a tie the pointer picks the winner
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = elig0 && (!elig1 || !rr_ptr_q);
      grant1 = elig1 && (!elig0 ||  rr_ptr_q);
    end
  end

  // Pointer moves to the other requester after every grant, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (grant0) begin
      rr_ptr_q <= 1'b1;
    end else if (grant1) begin
      rr_ptr_q <= 1'b0;
    end
  end
`else
  // Fixed priority: requester 1 only gets the ALU when requester 0 cannot use it
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = elig0;
      grant1 = elig1 && !elig0;
    end
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ALU operands follow the granted requester; requester 0 when idle
  always_comb begin
    alu_op_sel   = req0_aluop;
    alu_a_sel    = req0_a;
    alu_b_sel    = req0_b;
    alu_slts_sel = req0_slts;
    if (grant1) begin
      alu_op_sel   = req1_aluop;
      alu_a_sel    = req1_a;
      alu_b_sel    = req1_b;
      alu_slts_sel = req1_slts;
    end
  end

  alu u_alu (
    .aluop (alu_ops'(alu_op_sel)),
    .a     (alu_a_sel),
    .b     (alu_b_sel),
    .slts  (alu_slts_sel),
    .f     (alu_f)
  );

  // Response slot 0: a new grant overwrites, an accept without grant empties
  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp0_id_q    <= '0;
    end else if (grant0) begin
      resp0_valid_q <= 1'b1;
      resp0_data_q  <= alu_f;
      resp0_id_q    <= req0_id;
    end else if (resp0_valid_q && resp0_ready) begin
      resp0_valid_q <= 1'b0;
    end
  end

  // Response slot 1: same policy as slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      resp1_valid_q <= 1'b0;
      resp1_data_q  <= '0;
      resp1_id_q    <= '0;
    end else if (grant1) begin
      resp1_valid_q <= 1'b1;
      resp1_data_q  <= alu_f;
      resp1_id_q    <= req1_id;
    end else if (resp1_valid_q && resp1_ready) begin
      resp1_valid_q <= 1'b0;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp0_id    = resp0_id_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_data  = resp1_data_q;
  assign resp1_id    = resp1_id_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single `alu` instance between two execute-side requesters, for example the main execute path and an address-generation or multi-cycle helper path. Each request port uses a valid/ready handshake. The block grants at most one operation per cycle and evaluates it through the shared ALU. It registers the result into a per-requester response slot, which holds the result until the requester accepts it.

## Interface
Parameters:
- `ID_W`, default 4: width of the request tag, echoed unchanged on the response.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester i presents an operation.
- `req0_ready` / `req1_ready`  out  1  requester i is granted this cycle; the operation is consumed.
- `req0_aluop` / `req1_aluop`  in  3  ALU opcode, using the `rv32i_types` alu_op encoding.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands.
- `req0_slts` / `req1_slts`  in  1  compare modifier, passed to the ALU `slts` input.
- `req0_id` / `req1_id`  in  `ID_W`  request tag.
- `resp0_valid` / `resp1_valid`  out  1  response slot i holds a result.
- `resp0_ready` / `resp1_ready`  in  1  requester i accepts the response this cycle.
- `resp0_data` / `resp1_data`  out  32  registered ALU result.
- `resp0_id` / `resp1_id`  out  `ID_W`  tag of the operation that produced the result.

## Operation
Shared ALU:
- The block instantiates exactly one `alu`.
- Its inputs are muxed from the granted requester.
- When nothing is granted, the ALU inputs are driven from requester 0. The ALU output is then unused.
- ALU semantics are unchanged:
  - `sra` with `slts=1` gives a signed less-than result of 0 or 1.
  - `sub` with `slts=1` gives an unsigned less-than result of 0 or 1.

Eligibility:
- Requester i is eligible when `elig_i = reqi_valid && (!respi_valid || respi_ready)`.
- A full response slot blocks new grants to that requester only. It does not block the other requester.

Grant:
- At most one grant per cycle. `reqi_ready = grant_i`.
- `reqi_ready` is combinational from `reqi_valid`, `respi_*` and the priority state. This is legal because ready may depend on valid.
- A requester must hold `aluop`, `a`, `b`, `slts` and `id` stable while `valid` is high and `ready` is low. Dropping `valid` before grant is permitted.

Priority state:
- `rr_ptr` is a 1-bit register and resets to 0.
- If both requesters are eligible, requester `rr_ptr` wins.
- After any grant to requester g, `rr_ptr` becomes `!g`.
- With no grant, `rr_ptr` holds its value.
- A requester that is granted alone still updates `rr_ptr`.

Response slot i, updated on a clock edge:
- If `grant_i`: `respi_valid` becomes 1, `respi_data` becomes the ALU result `f`, and `respi_id` becomes `reqi_id`.
- Else if `respi_valid && respi_ready`: `respi_valid` becomes 0, and data/id hold their old values.
- Otherwise the slot holds its value.
- Simultaneous accept and grant on the same slot: the new result replaces the old one, and `respi_valid` stays 1.
- An `x` ALU result from an illegal opcode is captured as-is. The block does not check opcodes.

Reset:
- Every `respi_valid`, `respi_data` and `respi_id` resets to 0, and `rr_ptr` resets to 0.
- Any in-flight or unaccepted result is discarded.
- `reqi_ready` is forced to 0 while `rst` is high.

## Timing
- Grant in cycle N; `respi_valid` is high starting in cycle N+1.
- Result latency is 1 cycle.
- Aggregate throughput is 1 operation per cycle across both ports.
- Per-port throughput is 1 operation per cycle when the consumer asserts `respi_ready` continuously.
- Under contention with round-robin, each port sees 1 grant every 2 cycles.
- Back-pressure: if `respi_ready` is 0, at most one result is buffered per port, and that port stalls. There is no loss and no reordering within a port.
- There is no combinational path from `reqi_*` to `respi_*`. `respi_*` are register outputs.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin priority as described above, using `rr_ptr`.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority: requester 0 wins whenever it is eligible.
  - `rr_ptr` is not implemented.
  - Requester 1 is granted only when requester 0 is not eligible.
  - Starvation of requester 1 is permitted in this build.

## Test plan
- **Reset:** hold `rst` 2 cycles, with both `reqi_valid=1` during reset.
  - Required: `req*_ready=0`, all `resp*_valid=0`, `resp*_data=0`, `resp*_id=0`.
  - First grant after reset goes to requester 0.
- **Single op:** req0 add, a=5, b=7, id=3.
  - Required: `req0_ready=1` in cycle N.
  - Cycle N+1: `resp0_valid=1`, `resp0_data=12`, `resp0_id=3`.
- **Compare modifiers:**
  - req1 `sra` with `slts=1`, a=0xFFFFFFFF, b=1: `resp1_data=1`.
  - `sub` with `slts=1`, same operands: `resp1_data=0`.
  - `sub` with `slts=0`: `resp1_data=0xFFFFFFFE`.
- **Contention (RR build):** both requesters valid for 4 cycles, with `resp*_ready=1`.
  - Required grants: 0, 1, 0, 1.
  - Each response carries the correct id.
- **Back-pressure:** `resp0_ready=0` with req0 issuing 2 ops.
  - Required: the first op is captured, then `req0_ready=0`. Meanwhile req1 is granted every cycle.
  - Raising `resp0_ready` for 1 cycle grants the second op in that same cycle, and its result replaces the first on the next edge.
- **Fixed-priority build (`ALU_ARB_RR_EN` undefined):** both valid for 3 cycles.
  - Required: requester 0 granted all 3 cycles; `req1_ready` stays 0.
